// File: rtl/cpu_fwd_pkg.sv
// Shared forwarding definitions: source-select codes and default source count.
// Used by the operand-select register, the hazard unit and the debug monitor.
package cpu_fwd_pkg;

    localparam int unsigned OPSEL_SRC_REGFILE = 0;
    localparam int unsigned DEFAULT_NUM_FWD   = 2;

    // Select code for forwarding source i; code 0 is reserved for the register file.
    function automatic int unsigned src_code(input int unsigned i);
        return i + 1;
    endfunction

endpackage

// File: rtl/fwd_priority_match.sv
// Combinational priority matcher: finds the youngest forwarding source that writes src_addr.
module fwd_priority_match
    import cpu_fwd_pkg::*;
#(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NUM_FWD = DEFAULT_NUM_FWD,
    parameter int unsigned SEL_W   = $clog2(NUM_FWD + 1)
) (
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr,
    input  logic [NUM_FWD-1:0]        fwd_wr_en,
    input  logic [NUM_FWD-1:0]        fwd_ready,
    input  logic [ADDR_W-1:0]         src_addr,
    output logic                      match_any,
    output logic [SEL_W-1:0]          winner,
    output logic                      winner_ready
);

    always_comb begin
        match_any    = 1'b0;
        winner       = '0;
        winner_ready = 1'b0;
        // Scan oldest to youngest so the lowest matching index is the last to write.
        for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
            if (fwd_wr_en[i] && (fwd_addr[i*ADDR_W +: ADDR_W] == src_addr) &&
                (src_addr != '0)) begin
                match_any    = 1'b1;
                winner       = SEL_W'(i);
                winner_ready = fwd_ready[i];
            end
        end
    end

endmodule

// File: rtl/fwd_operand_select_reg.sv
// Forwarding operand mux with load-use hazard detection, registered into ID/EX.
// Optional OPSEL_STATS_EN adds saturating forward/hazard counters.
module fwd_operand_select_reg
    import cpu_fwd_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NUM_FWD = DEFAULT_NUM_FWD,
    parameter int unsigned SEL_W   = $clog2(NUM_FWD + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [ADDR_W-1:0]         src_addr,
    input  logic [DATA_W-1:0]         rf_data,
    input  logic [NUM_FWD-1:0]        fwd_wr_en,
    input  logic [NUM_FWD-1:0]        fwd_ready,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    output logic                      hazard,
    output logic [DATA_W-1:0]         out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid
`ifdef OPSEL_STATS_EN
    ,
    output logic [NUM_FWD*16-1:0]     stat_fwd_cnt,
    output logic [15:0]               stat_hazard_cnt
`endif
);

    logic              match_any;
    logic [SEL_W-1:0]  winner;
    logic              winner_ready;
    logic [DATA_W-1:0] sel_data;
    logic [SEL_W-1:0]  sel_code;
    logic [DATA_W-1:0] data_q;
    logic [SEL_W-1:0]  sel_q;
    logic              valid_q;
    logic              bubble;

    fwd_priority_match #(
        .ADDR_W  (ADDR_W),
        .NUM_FWD (NUM_FWD),
        .SEL_W   (SEL_W)
    ) u_match (
        .fwd_addr     (fwd_addr),
        .fwd_wr_en    (fwd_wr_en),
        .fwd_ready    (fwd_ready),
        .src_addr     (src_addr),
        .match_any    (match_any),
        .winner       (winner),
        .winner_ready (winner_ready)
    );

    always_comb begin
        sel_data = rf_data;
        sel_code = SEL_W'(OPSEL_SRC_REGFILE);
        for (int i = 0; i < int'(NUM_FWD); i++) begin
            if (match_any && (winner == SEL_W'(i))) begin
                sel_data = fwd_data[i*DATA_W +: DATA_W];
                sel_code = SEL_W'(src_code(i));
            end
        end
    end

    assign hazard = in_valid && match_any && !winner_ready;

    // Reset, flush and an unstalled hazard all load a bubble; flush overrides stall.
    assign bubble = reset || flush || (!stall && hazard);

    always_ff @(posedge clk) begin
        if (bubble) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else if (!stall) begin
            data_q  <= sel_data;
            sel_q   <= sel_code;
            valid_q <= in_valid;
        end
    end

    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign out_valid = valid_q;

`ifdef OPSEL_STATS_EN
    logic [15:0] fwd_cnt_q [NUM_FWD];
    logic [15:0] hazard_cnt_q;
    logic        capture_fwd;

    assign capture_fwd = !reset && !flush && !stall && !hazard && in_valid && match_any;

    always_ff @(posedge clk) begin
        if (reset) begin
            hazard_cnt_q <= '0;
            for (int i = 0; i < int'(NUM_FWD); i++) begin
                fwd_cnt_q[i] <= '0;
            end
        end else begin
            if (hazard && !stall && (hazard_cnt_q != 16'hFFFF)) begin
                hazard_cnt_q <= hazard_cnt_q + 16'd1;
            end
            for (int i = 0; i < int'(NUM_FWD); i++) begin
                if (capture_fwd && (winner == SEL_W'(i)) && (fwd_cnt_q[i] != 16'hFFFF)) begin
                    fwd_cnt_q[i] <= fwd_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        stat_fwd_cnt = '0;
        for (int i = 0; i < int'(NUM_FWD); i++) begin
            stat_fwd_cnt[i*16 +: 16] = fwd_cnt_q[i];
        end
    end

    assign stat_hazard_cnt = hazard_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_operand_select_reg.sv
// Self-checking bench: directed cases plus randomized traffic against a behavioural model.
module tb_fwd_operand_select_reg;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NF = 2;
    localparam int SW = $clog2(NF + 1);

    logic          clk = 1'b0;
    logic          reset, stall, flush, in_valid;
    logic [AW-1:0] src_addr;
    logic [DW-1:0] rf_data;
    logic [NF-1:0] wr_en, ready;
    logic [AW-1:0] f_addr [NF];
    logic [DW-1:0] f_data [NF];
    logic [NF*AW-1:0] fwd_addr;
    logic [NF*DW-1:0] fwd_data;
    logic          hazard, out_valid;
    logic [DW-1:0] out_data;
    logic [SW-1:0] out_sel;
`ifdef OPSEL_STATS_EN
    logic [NF*16-1:0] stat_fwd_cnt;
    logic [15:0]      stat_hazard_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural expectation of the output register.
    logic [DW-1:0] m_data;
    int            m_sel;
    logic          m_valid;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NF; i++) begin
            fwd_addr[i*AW +: AW] = f_addr[i];
            fwd_data[i*DW +: DW] = f_data[i];
        end
    end

    fwd_operand_select_reg #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .NUM_FWD (NF),
        .SEL_W   (SW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .src_addr  (src_addr),
        .rf_data   (rf_data),
        .fwd_wr_en (wr_en),
        .fwd_ready (ready),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .hazard    (hazard),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid)
`ifdef OPSEL_STATS_EN
        ,
        .stat_fwd_cnt    (stat_fwd_cnt),
        .stat_hazard_cnt (stat_hazard_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Youngest matching source wins; $0 never forwards.
    task automatic model_eval(output logic hz, output logic [DW-1:0] d, output int code);
        int idx;
        idx = -1;
        for (int i = NF - 1; i >= 0; i--) begin
            if (wr_en[i] && f_addr[i] == src_addr && src_addr != 0) idx = i;
        end
        if (idx < 0) begin
            hz = 1'b0;
            d = rf_data;
            code = 0;
        end else begin
            hz = in_valid && !ready[idx];
            d = f_data[idx];
            code = idx + 1;
        end
    endtask

    // Inputs are already applied; check hazard, clock once, check the register.
    task automatic step();
        logic hz;
        logic [DW-1:0] d;
        int code;
        #1;
        model_eval(hz, d, code);
        check_eq("hazard", 32'(hazard), 32'(hz));
        if (reset || flush || (!stall && hz)) begin
            m_data = '0;
            m_sel = 0;
            m_valid = 1'b0;
        end else if (!stall) begin
            m_data = d;
            m_sel = code;
            m_valid = in_valid;
        end
        @(posedge clk);
        #1;
        check_eq("out_data", out_data, m_data);
        check_eq("out_sel", 32'(out_sel), 32'(m_sel));
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    endtask

    task automatic clear_inputs();
        reset = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b1;
        src_addr = '0; rf_data = '0; wr_en = '0; ready = '1;
        for (int i = 0; i < NF; i++) begin
            f_addr[i] = '0;
            f_data[i] = '0;
        end
    endtask

    initial begin
        m_data = '0; m_sel = 0; m_valid = 1'b0;
        clear_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        step();
        step();
        check_eq("reset_valid", 32'(out_valid), 32'd0);

        // Register file path
        reset = 1'b0; src_addr = 5; rf_data = 32'h1111_1111;
        step();
        check_eq("rf_data", out_data, 32'h1111_1111);
        check_eq("rf_sel", 32'(out_sel), 32'd0);

        // Priority: youngest source wins, then older when younger is disabled
        src_addr = 8; wr_en = 2'b11; ready = 2'b11;
        f_addr[0] = 8; f_addr[1] = 8;
        f_data[0] = 32'hAAAA_0000; f_data[1] = 32'hBBBB_0000;
        step();
        check_eq("prio0_data", out_data, 32'hAAAA_0000);
        check_eq("prio0_sel", 32'(out_sel), 32'd1);
        wr_en = 2'b10;
        step();
        check_eq("prio1_data", out_data, 32'hBBBB_0000);
        check_eq("prio1_sel", 32'(out_sel), 32'd2);

        // Register zero never forwards
        src_addr = 0; wr_en = 2'b01; f_addr[0] = 0; rf_data = 0;
        step();
        check_eq("r0_sel", 32'(out_sel), 32'd0);
        check_eq("r0_data", out_data, 32'd0);

        // Load-use hazard; ready older source must not override
        src_addr = 9; wr_en = 2'b11; f_addr[0] = 9; f_addr[1] = 9; ready = 2'b10;
        f_data[0] = 32'h0000_0900;
        #1;
        check_eq("lu_hazard", 32'(hazard), 32'd1);
        step();
        check_eq("lu_bubble", 32'(out_valid), 32'd0);
        ready = 2'b11;
        #1;
        check_eq("lu_clear", 32'(hazard), 32'd0);
        step();
        check_eq("lu_data", out_data, 32'h0000_0900);

        // Hazard masked when in_valid=0
        in_valid = 1'b0; ready = 2'b00;
        step();
        in_valid = 1'b1;

        // Stall holds, flush beats stall
        wr_en = '0; src_addr = 3; rf_data = 32'hCAFE_F00D;
        step();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rf_data = $urandom; src_addr = 5'($urandom);
            step();
        end
        check_eq("stall_hold", out_data, 32'hCAFE_F00D);
        flush = 1'b1;
        step();
        check_eq("flush_valid", 32'(out_valid), 32'd0);
        check_eq("flush_data", out_data, 32'd0);

        // Reset mid-stall with a pending hazard
        flush = 1'b0; stall = 1'b0; src_addr = 4; rf_data = 32'h1234_5678;
        step();
        stall = 1'b1; reset = 1'b1; wr_en = 2'b01; f_addr[0] = 4; ready = 2'b00;
        step();
        clear_inputs();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            reset    = ($urandom_range(0, 31) == 0);
            stall    = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 7) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            src_addr = 5'($urandom_range(0, 3));
            rf_data  = $urandom;
            wr_en    = 2'($urandom);
            ready    = 2'($urandom);
            for (int i = 0; i < NF; i++) begin
                f_addr[i] = 5'($urandom_range(0, 3));
                f_data[i] = $urandom;
            end
            step();
        end

`ifdef OPSEL_STATS_EN
        clear_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; src_addr = 3; wr_en = 2'b01; f_addr[0] = 3; ready = 2'b11;
        repeat (70000) @(posedge clk);
        #1;
        check_eq("stat_sat", 32'(stat_fwd_cnt[15:0]), 32'h0000_FFFF);
        check_eq("stat_src1", 32'(stat_fwd_cnt[31:16]), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("stat_reset", 32'(stat_fwd_cnt[15:0]), 32'd0);
        check_eq("stat_hz_reset", 32'(stat_hazard_cnt), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
